// File: rtl/flght_pkg.sv
// Shared widths, constants and saturation helpers for the attitude PD controller.
package flght_pkg;

   localparam int unsigned ANG_W      = 16;
   localparam int unsigned ERR_W      = 17;
   localparam int unsigned ERR_SAT_W  = 10;
   localparam int unsigned P_PROD_W   = ERR_SAT_W + 3;
   localparam int unsigned DIFF_W     = 11;
   localparam int unsigned DIFF_SAT_W = 7;
   localparam int unsigned PD_W       = 12;
   localparam int unsigned MIX_W      = 13;
   localparam int unsigned THRST_W    = 9;
   localparam int unsigned SPD_W      = 11;

   localparam int unsigned MIN_RUN_SPEED = 704;
   localparam int unsigned CAL_SPEED     = 432;
   localparam int unsigned P_NUM         = 5;
   localparam int unsigned P_SHIFT       = 3;
   localparam int unsigned D_COEFF       = 7;

   // Saturate a signed error to ERR_SAT_W bits: in range iff the dropped bits match the sign.
   function automatic logic [ERR_SAT_W-1:0] sat_err(input logic [ERR_W-1:0] x);
      logic [ERR_W-ERR_SAT_W:0] top;
      top = x[ERR_W-1:ERR_SAT_W-1];
      if (top == '0 || top == '1) sat_err = x[ERR_SAT_W-1:0];
      else if (x[ERR_W-1])        sat_err = {1'b1, {(ERR_SAT_W-1){1'b0}}};
      else                        sat_err = {1'b0, {(ERR_SAT_W-1){1'b1}}};
   endfunction

   function automatic logic [DIFF_SAT_W-1:0] sat_diff(input logic [DIFF_W-1:0] x);
      logic [DIFF_W-DIFF_SAT_W:0] top;
      top = x[DIFF_W-1:DIFF_SAT_W-1];
      if (top == '0 || top == '1) sat_diff = x[DIFF_SAT_W-1:0];
      else if (x[DIFF_W-1])       sat_diff = {1'b1, {(DIFF_SAT_W-1){1'b0}}};
      else                        sat_diff = {1'b0, {(DIFF_SAT_W-1){1'b1}}};
   endfunction

   // Clip a signed mix sum to the unsigned motor range [0, 2^SPD_W-1].
   function automatic logic [SPD_W-1:0] clip_spd(input logic [MIX_W-1:0] x);
      if (x[MIX_W-1])                   clip_spd = '0;
      else if (x[MIX_W-2:SPD_W] != '0)  clip_spd = '1;
      else                              clip_spd = x[SPD_W-1:0];
   endfunction

endpackage

// File: rtl/axis_pd.sv
// One attitude axis: error saturation, derivative history queue, P/D terms (stages 1-2).
module axis_pd
   import flght_pkg::*;
#(
   parameter int unsigned D_QUEUE_DEPTH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vld,
   input  logic              stg2_en,
   input  logic [ANG_W-1:0]  act,
   input  logic [ANG_W-1:0]  des,
   output logic [PD_W-1:0]   pd
);

   logic [ERR_SAT_W-1:0] hist_q [D_QUEUE_DEPTH];
   logic [ERR_SAT_W-1:0] hist_d [D_QUEUE_DEPTH];
   logic [ERR_SAT_W-1:0] err_sat_q, err_sat_d;
   logic [ERR_SAT_W-1:0] prev_q, prev_d;
   logic [PD_W-1:0]      pd_q, pd_d;

   logic [ERR_W-1:0]           err;
   logic signed [P_PROD_W-1:0] p_full;
   logic signed [PD_W-1:0]     p_term, d_term;
   logic [DIFF_W-1:0]          diff;
   logic [DIFF_SAT_W-1:0]      diff_sat;

   // Stage 1: the oldest queue entry is read out as prev before the new error shifts in.
   always_comb begin
      err       = ERR_W'($signed(act)) - ERR_W'($signed(des));
      err_sat_d = err_sat_q;
      prev_d    = prev_q;
      hist_d    = hist_q;
      if (vld) begin
         err_sat_d = sat_err(err);
         prev_d    = hist_q[D_QUEUE_DEPTH-1];
         hist_d[0] = err_sat_d;
         for (int unsigned i = 1; i < D_QUEUE_DEPTH; i++) hist_d[i] = hist_q[i-1];
      end
   end

   // Stage 2: P = (e*5)>>>3, D = sat7(e - prev)*7.
   always_comb begin
      p_full   = $signed(P_PROD_W'($signed(err_sat_q))) * $signed(P_PROD_W'(P_NUM));
      p_term   = PD_W'(p_full >>> P_SHIFT);
      diff     = DIFF_W'($signed(err_sat_q)) - DIFF_W'($signed(prev_q));
      diff_sat = sat_diff(diff);
      d_term   = $signed(PD_W'($signed(diff_sat))) * $signed(PD_W'(D_COEFF));
      pd_d     = pd_q;
      if (stg2_en) pd_d = p_term + d_term;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < D_QUEUE_DEPTH; i++) hist_q[i] <= '0;
         err_sat_q <= '0;
         prev_q    <= '0;
         pd_q      <= '0;
      end else begin
         hist_q    <= hist_d;
         err_sat_q <= err_sat_d;
         prev_q    <= prev_d;
         pd_q      <= pd_d;
      end
   end

   assign pd = pd_q;

endmodule

// File: rtl/flght_cntrl_pd.sv
// Three-axis attitude PD controller with quad motor mixing, clipping and calibration override.
module flght_cntrl_pd
   import flght_pkg::*;
#(
   parameter int unsigned D_QUEUE_DEPTH = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vld,
   input  logic [ANG_W-1:0]    ptch,
   input  logic [ANG_W-1:0]    roll,
   input  logic [ANG_W-1:0]    yaw,
   input  logic [ANG_W-1:0]    d_ptch,
   input  logic [ANG_W-1:0]    d_roll,
   input  logic [ANG_W-1:0]    d_yaw,
   input  logic [THRST_W-1:0]  thrst,
   input  logic                inertial_cal,
   output logic [SPD_W-1:0]    frnt_spd,
   output logic [SPD_W-1:0]    bck_spd,
   output logic [SPD_W-1:0]    lft_spd,
   output logic [SPD_W-1:0]    rght_spd,
   output logic                spd_vld
);

   logic                vld1_q, vld1_d, vld2_q, vld2_d;
   logic [THRST_W-1:0]  thrst1_q, thrst1_d, thrst2_q, thrst2_d;
   logic [SPD_W-1:0]    frnt_q, frnt_d, bck_q, bck_d, lft_q, lft_d, rght_q, rght_d;
   logic                spd_vld_q, spd_vld_d;
   logic [PD_W-1:0]     ptch_pd, roll_pd, yaw_pd;

   logic signed [MIX_W-1:0] base, p_s, r_s, y_s;

   axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_ptch (
      .clk(clk), .rst_n(rst_n), .vld(vld), .stg2_en(vld1_q),
      .act(ptch), .des(d_ptch), .pd(ptch_pd)
   );

   axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_roll (
      .clk(clk), .rst_n(rst_n), .vld(vld), .stg2_en(vld1_q),
      .act(roll), .des(d_roll), .pd(roll_pd)
   );

   axis_pd #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_yaw (
      .clk(clk), .rst_n(rst_n), .vld(vld), .stg2_en(vld1_q),
      .act(yaw), .des(d_yaw), .pd(yaw_pd)
   );

   // Valid and thrust travel alongside the axis pipelines.
   always_comb begin
      vld1_d   = vld;
      vld2_d   = vld1_q;
      thrst1_d = vld    ? thrst    : thrst1_q;
      thrst2_d = vld1_q ? thrst1_q : thrst2_q;
   end

   // Stage 3: mix and clip; calibration overrides the speeds but not the valid pulse.
   always_comb begin
      base      = $signed(MIX_W'(MIN_RUN_SPEED) + MIX_W'(thrst2_q));
      p_s       = MIX_W'($signed(ptch_pd));
      r_s       = MIX_W'($signed(roll_pd));
      y_s       = MIX_W'($signed(yaw_pd));
      frnt_d    = frnt_q;
      bck_d     = bck_q;
      lft_d     = lft_q;
      rght_d    = rght_q;
      spd_vld_d = vld2_q;
      if (inertial_cal) begin
         frnt_d = SPD_W'(CAL_SPEED);
         bck_d  = SPD_W'(CAL_SPEED);
         lft_d  = SPD_W'(CAL_SPEED);
         rght_d = SPD_W'(CAL_SPEED);
      end else if (vld2_q) begin
         frnt_d = clip_spd(base - p_s - y_s);
         bck_d  = clip_spd(base + p_s - y_s);
         lft_d  = clip_spd(base - r_s + y_s);
         rght_d = clip_spd(base + r_s + y_s);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1_q    <= 1'b0;
         vld2_q    <= 1'b0;
         thrst1_q  <= '0;
         thrst2_q  <= '0;
         frnt_q    <= '0;
         bck_q     <= '0;
         lft_q     <= '0;
         rght_q    <= '0;
         spd_vld_q <= 1'b0;
      end else begin
         vld1_q    <= vld1_d;
         vld2_q    <= vld2_d;
         thrst1_q  <= thrst1_d;
         thrst2_q  <= thrst2_d;
         frnt_q    <= frnt_d;
         bck_q     <= bck_d;
         lft_q     <= lft_d;
         rght_q    <= rght_d;
         spd_vld_q <= spd_vld_d;
      end
   end

   assign frnt_spd = frnt_q;
   assign bck_spd  = bck_q;
   assign lft_spd  = lft_q;
   assign rght_spd = rght_q;
   assign spd_vld  = spd_vld_q;

endmodule

// File: doc/flght_cntrl_pd.md
# flght_cntrl_pd

Attitude PD controller that consumes the fused pitch/roll/yaw angles and the `vld` strobe produced by the inertial interface, compares them against commanded set-points, and produces four saturated motor speed commands. It sits directly downstream of the inertial interface and upstream of the ESC/PWM generators. The pipeline is 3 stages and accepts a new sample on any cycle.

## Interface
- `D_QUEUE_DEPTH`, 12: number of past valid samples spanned by the derivative term.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vld`  in  1  one-cycle strobe: `ptch`/`roll`/`yaw` are new.
- `ptch`, `roll`, `yaw`  in  16 signed each  fused measured angles.
- `d_ptch`, `d_roll`, `d_yaw`  in  16 signed each  desired angles; sampled only on `vld`.
- `thrst`  in  9 unsigned  collective thrust; sampled only on `vld`.
- `inertial_cal`  in  1  calibration in progress; forces the calibration speed.
- `frnt_spd`, `bck_spd`, `lft_spd`, `rght_spd`  out  11 unsigned each  motor commands.
- `spd_vld`  out  1  one-cycle pulse when the motor outputs hold a new vld-derived result.

## Operation
- Per axis, on `vld`:
  - err = actual − desired, computed at 17 bits signed.
  - err_sat = err saturated to 10-bit signed [−512, 511].
- History:
  - Each axis has a `D_QUEUE_DEPTH`-entry shift queue of err_sat.
  - The queue shifts only on `vld`, never on idle cycles.
  - prev = the entry written `D_QUEUE_DEPTH` valid samples ago. It is 0 until the queue has filled after reset.
- P term: P = (err_sat × 5) >>> 3, arithmetic shift, range [−320, 319].
- D term:
  - diff = err_sat − prev, computed at 11 bits.
  - diff is saturated to 7-bit signed [−64, 63].
  - D = diff_sat × 7.
- pd = P + D, 12-bit signed, giving ptch_pd, roll_pd and yaw_pd.
- Motor mix, with base = MIN_RUN_SPEED (704) + thrst:
  - frnt = base − ptch_pd − yaw_pd
  - bck = base + ptch_pd − yaw_pd
  - lft = base − roll_pd + yaw_pd
  - rght = base + roll_pd + yaw_pd
  - Each sum is computed at 13 bits signed, then clipped to [0, 2047].
- Calibration override:
  - While `inertial_cal` is 1, the output registers load CAL_SPEED (432) every cycle.
  - The queues and pipeline keep advancing normally.
  - `spd_vld` still pulses in this mode.
- Reset, including reset asserted mid-operation:
  - All queues, pipeline registers, speed outputs and `spd_vld` clear to 0 asynchronously.
  - No partial result emerges after reset is released.

## Timing
- `vld` sampled at edge N:
  - stage 1 (err_sat, prev, thrst) registered at N+1.
  - stage 2 (P, D, pd) registered at N+2.
  - stage 3 (speeds) registered at N+3, with `spd_vld` = 1 for exactly that cycle.
- Back-to-back `vld` on consecutive cycles gives consecutive `spd_vld` pulses, in order, none dropped.
- Without `vld`, outputs hold their last value, except that `inertial_cal` forces CAL_SPEED from the cycle after it rises.
- On `inertial_cal` fall, outputs hold CAL_SPEED until the next vld-derived result reaches stage 3.
- Set-point or thrust changes between `vld` strobes have no effect until the next `vld`.

## Structure
- Package `flght_pkg` holds:
  - MIN_RUN_SPEED, CAL_SPEED, P_NUM = 5, P_SHIFT = 3, D_COEFF = 7.
  - Saturation widths.
  - Generic signed-saturate functions.
- Sub-module `axis_pd` (one axis):
  - Contains the error saturation, history queue, and P/D stages 1–2.
  - Instantiated three times.
  - Motor mixing and clipping (stage 3) live in the top level.

## Test plan
- Reset, then one `vld` with ptch = 100 and all other inputs 0 → at N+3: frnt = 201, bck = 1207, lft = rght = 704, `spd_vld` = 1 for one cycle.
- Hold ptch = 100 for 13 consecutive `vld` strobes (queue filled, diff = 0) → the final result is frnt = 642, bck = 766.
- ptch = 32767, d_ptch = −32768, yaw = −30000, thrst = 511 → ptch_pd = 760, yaw_pd = −768; bck clips to 2047, frnt = 1223, lft = rght = 447.
- Assert `inertial_cal` with no `vld` → all four speeds = 432 on the next cycle and stay there. Deassert, then send one `vld` → normal values appear 3 cycles later.
- Eight back-to-back `vld` strobes with a changing ptch → eight consecutive `spd_vld` pulses, each carrying the matching result. Also assert `rst_n` low mid-burst → all outputs 0 immediately, and no `spd_vld` appears after release.
